// File: rtl/alu_req_arbiter_if.sv
// Handshake bundles for the ALU arbiter: requester channel, response channel
// and the operand/result connection to the shared ALU_Top.
interface alu_req_if #(parameter int width = 16);
   logic             valid;
   logic             ready;
   logic [3:0]       fun;
   logic [width-1:0] a;
   logic [width-1:0] b;

   modport master (output valid, fun, a, b, input ready);
   modport slave  (input valid, fun, a, b, output ready);
endinterface

interface alu_rsp_if #(parameter int width = 16);
   logic               valid;
   logic               ready;
   logic               id;
   logic [2*width-1:0] data;
   logic               flag;
   logic               carry;

   modport master (output valid, id, data, flag, carry, input ready);
   modport slave  (input valid, id, data, flag, carry, output ready);
endinterface

interface alu_core_if #(parameter int width = 16);
   logic [width-1:0]   a;
   logic [width-1:0]   b;
   logic [3:0]         fun;
   logic [2*width-1:0] arith_out;
   logic [width-1:0]   logic_out;
   logic [width-1:0]   shift_out;
   logic [1:0]         cmp_out;
   logic               carry_out;
   logic               arith_flag;
   logic               logic_flag;
   logic               cmp_flag;
   logic               shift_flag;

   modport master (output a, b, fun,
                   input  arith_out, logic_out, shift_out, cmp_out, carry_out,
                          arith_flag, logic_flag, cmp_flag, shift_flag);
   modport slave  (input  a, b, fun,
                   output arith_out, logic_out, shift_out, cmp_out, carry_out,
                          arith_flag, logic_flag, cmp_flag, shift_flag);
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-requester front end for one shared ALU_Top; one operation in flight at a time.
// ALU_ARB_FIXED_PRIO_EN: req0 always wins on contention (default is round-robin).
//
// state | meaning
// IDLE  | waiting for a request; ready goes to the granted requester
// EXEC  | operands held on the ALU, counting out its latency
// RESP  | result held on the response channel until taken
module alu_req_arbiter #(
   parameter int width   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   alu_req_if.slave   req0,
   alu_req_if.slave   req1,
   alu_rsp_if.master  rsp,
   alu_core_if.master alu
);

   localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [width-1:0]   alu_a_q;
   logic [width-1:0]   alu_b_q;
   logic [3:0]         alu_fun_q;
   logic               rsp_valid_q;
   logic               rsp_id_q;
   logic [2*width-1:0] rsp_data_q;
   logic               rsp_flag_q;
   logic               rsp_carry_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic               rr_q;
`endif

   logic               gnt_any_d;
   logic               gnt_id_d;
   logic [2*width-1:0] res_data_d;
   logic               res_flag_d;
   logic               res_carry_d;

   // Ready is held low during reset so every output reads 0 while it is asserted.
   always_comb begin
      gnt_any_d = !reset && (state_q == IDLE) && (req0.valid || req1.valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_id_d  = !req0.valid;
`else
      gnt_id_d  = (req0.valid && req1.valid) ? !rr_q : !req0.valid;
`endif
   end

   always_comb begin
      res_data_d  = '0;
      res_flag_d  = 1'b0;
      res_carry_d = 1'b0;
      case (alu_fun_q[3:2])
         2'b00: begin
            res_data_d  = alu.arith_out;
            res_flag_d  = alu.arith_flag;
            res_carry_d = alu.carry_out;
         end
         2'b01: begin
            res_data_d = {{width{1'b0}}, alu.logic_out};
            res_flag_d = alu.logic_flag;
         end
         2'b10: begin
            res_data_d = {{(2*width-2){1'b0}}, alu.cmp_out};
            res_flag_d = alu.cmp_flag;
         end
         default: begin
            res_data_d = {{width{1'b0}}, alu.shift_out};
            res_flag_d = alu.shift_flag;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fun_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flag_q  <= 1'b0;
         rsp_carry_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         rr_q        <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_any_d) begin
                  alu_a_q   <= gnt_id_d ? req1.a   : req0.a;
                  alu_b_q   <= gnt_id_d ? req1.b   : req0.b;
                  alu_fun_q <= gnt_id_d ? req1.fun : req0.fun;
                  rsp_id_q  <= gnt_id_d;
                  cnt_q     <= '0;
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_q == CNT_W'(ALU_LAT)) begin
                  rsp_data_q  <= res_data_d;
                  rsp_flag_q  <= res_flag_d;
                  rsp_carry_q <= res_carry_d;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp.ready) begin
                  rsp_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  rr_q        <= rsp_id_q;
`endif
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req0.ready = gnt_any_d && !gnt_id_d;
   assign req1.ready = gnt_any_d &&  gnt_id_d;
   assign rsp.valid  = rsp_valid_q;
   assign rsp.id     = rsp_id_q;
   assign rsp.data   = rsp_data_q;
   assign rsp.flag   = rsp_flag_q;
   assign rsp.carry  = rsp_carry_q;
   assign alu.a      = alu_a_q;
   assign alu.b      = alu_b_q;
   assign alu.fun    = alu_fun_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter with a registered ALU_Top stand-in and a
// transaction-level reference for arbitration order and response contents.
module tb_alu_req_arbiter;

   localparam int W       = 16;
   localparam int ALU_LAT = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_req_if  #(.width(W)) req0_if ();
   alu_req_if  #(.width(W)) req1_if ();
   alu_rsp_if  #(.width(W)) rsp_if ();
   alu_core_if #(.width(W)) alu_if ();

   alu_req_arbiter #(.width(W), .ALU_LAT(ALU_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .req0  (req0_if),
      .req1  (req1_if),
      .rsp   (rsp_if),
      .alu   (alu_if)
   );

   typedef struct packed {
      logic [31:0] ar;
      logic [15:0] lo;
      logic [15:0] sh;
      logic [1:0]  cm;
      logic        cy;
      logic        af;
      logic        lf;
      logic        cf;
      logic        sf;
   } alu_res_t;

   // All four units compute every cycle; the arbiter must pick the right one.
   function automatic alu_res_t alu_eval(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      alu_res_t   r;
      logic [16:0] s;
      r = '0;
      s = '0;
      case (f[1:0])
         2'd0: begin s = {1'b0, a} + {1'b0, b}; r.ar = {15'd0, s}; r.cy = s[16]; end
         2'd1: begin s = {1'b0, a} - {1'b0, b}; r.ar = {16'd0, s[15:0]}; r.cy = s[16]; end
         2'd2: r.ar = {16'd0, a} * {16'd0, b};
         default: r.ar = (b == 16'd0) ? 32'd0 : {16'd0, a / b};
      endcase
      r.af = (r.ar == 32'd0);
      case (f[1:0])
         2'd0: r.lo = a & b;
         2'd1: r.lo = a | b;
         2'd2: r.lo = ~(a & b);
         default: r.lo = ~(a | b);
      endcase
      r.lf = r.lo[0];
      case (f[1:0])
         2'd0: r.cm = 2'd0;
         2'd1: r.cm = (a == b) ? 2'd1 : 2'd0;
         2'd2: r.cm = (a > b)  ? 2'd2 : 2'd0;
         default: r.cm = (a < b) ? 2'd3 : 2'd0;
      endcase
      r.cf = |r.cm;
      case (f[1:0])
         2'd0: r.sh = a >> 1;
         2'd1: r.sh = a << 1;
         2'd2: r.sh = b >> 1;
         default: r.sh = b << 1;
      endcase
      r.sf = r.sh[15];
      return r;
   endfunction

   alu_res_t pipe [ALU_LAT];
   always @(posedge clk) begin
      pipe[0] <= alu_eval(alu_if.fun, alu_if.a, alu_if.b);
      for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign alu_if.arith_out  = pipe[ALU_LAT-1].ar;
   assign alu_if.logic_out  = pipe[ALU_LAT-1].lo;
   assign alu_if.shift_out  = pipe[ALU_LAT-1].sh;
   assign alu_if.cmp_out    = pipe[ALU_LAT-1].cm;
   assign alu_if.carry_out  = pipe[ALU_LAT-1].cy;
   assign alu_if.arith_flag = pipe[ALU_LAT-1].af;
   assign alu_if.logic_flag = pipe[ALU_LAT-1].lf;
   assign alu_if.cmp_flag   = pipe[ALU_LAT-1].cf;
   assign alu_if.shift_flag = pipe[ALU_LAT-1].sf;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference arbitration: the valid requester served longest ago wins.
   int last_served [2];
   int serve_time;

   task automatic model_reset();
      last_served[0] = -2;
      last_served[1] = -1;
      serve_time     = 0;
   endtask

   function automatic bit model_grant(input bit v0, input bit v1);
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         return 1'b0;
`else
         return (last_served[0] <= last_served[1]) ? 1'b0 : 1'b1;
`endif
      end
      return v1 && !v0;
   endfunction

   task automatic model_serve(input bit id);
      last_served[id] = serve_time;
      serve_time++;
   endtask

   task automatic ref_rsp(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] d, output logic fl, output logic cy);
      alu_res_t r;
      r = alu_eval(f, a, b);
      case (f[3:2])
         2'b00: begin d = r.ar;          fl = r.af; cy = r.cy; end
         2'b01: begin d = {16'd0, r.lo}; fl = r.lf; cy = 1'b0; end
         2'b10: begin d = {30'd0, r.cm}; fl = r.cf; cy = 1'b0; end
         default: begin d = {16'd0, r.sh}; fl = r.sf; cy = 1'b0; end
      endcase
   endtask

   task automatic drop_valids();
      req0_if.valid = 1'b0;
      req1_if.valid = 1'b0;
   endtask

   task automatic rand_valids();
      req0_if.valid = 1'($urandom);
      req1_if.valid = 1'($urandom);
   endtask

   // Called at a negedge with the arbiter idle.
   task automatic do_op(input bit v0, input bit v1,
                        input logic [3:0] f0, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [3:0] f1, input logic [15:0] a1, input logic [15:0] b1,
                        input int stall, input bit poke,
                        output bit gid_o, output logic [31:0] data_o, output logic carry_o);
      bit          gid;
      logic [3:0]  wf;
      logic [15:0] wa, wb;
      logic [31:0] ed;
      logic        ef, ec;
      int          lat;
      bit          seen;
      req0_if.valid = v0; req0_if.fun = f0; req0_if.a = a0; req0_if.b = b0;
      req1_if.valid = v1; req1_if.fun = f1; req1_if.a = a1; req1_if.b = b1;
      gid = model_grant(v0, v1);
      wf  = gid ? f1 : f0;
      wa  = gid ? a1 : a0;
      wb  = gid ? b1 : b0;
      ref_rsp(wf, wa, wb, ed, ef, ec);
      #1;
      chk("grant", 64'({req1_if.ready, req0_if.ready}), 64'(gid ? 2'b10 : 2'b01));
      gid_o = req1_if.ready;
      @(posedge clk); lat = 1;
      @(negedge clk); drop_valids();
      chk("alu_a", 64'(alu_if.a), 64'(wa));
      chk("alu_b", 64'(alu_if.b), 64'(wb));
      chk("alu_fun", 64'(alu_if.fun), 64'(wf));
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         if (rsp_if.valid) seen = 1'b1;
         else begin
            rand_valids();
            rsp_if.ready = 1'($urandom);
            #1;
            chk("busy_ready", 64'({req1_if.ready, req0_if.ready}), 64'd0);
            @(posedge clk); lat++;
            @(negedge clk); drop_valids();
         end
      end
      chk("rsp_seen", 64'(seen), 64'd1);
      chk("latency", 64'(lat), 64'(ALU_LAT + 2));
      chk("rsp_id", 64'(rsp_if.id), 64'(gid));
      chk("rsp_data", 64'(rsp_if.data), 64'(ed));
      chk("rsp_flag", 64'(rsp_if.flag), 64'(ef));
      chk("rsp_carry", 64'(rsp_if.carry), 64'(ec));
      data_o  = rsp_if.data;
      carry_o = rsp_if.carry;
      for (int s = 0; s < stall; s++) begin
         rsp_if.ready = 1'b0;
         if (poke && s == 0) begin
            req0_if.valid = 1'b0;
            req1_if.valid = 1'b1;
         end else rand_valids();
         #1;
         chk("stall_ready", 64'({req1_if.ready, req0_if.ready}), 64'd0);
         @(posedge clk);
         @(negedge clk); drop_valids();
         chk("stall_valid", 64'(rsp_if.valid), 64'd1);
         chk("stall_data", 64'(rsp_if.data), 64'(ed));
         chk("stall_id", 64'(rsp_if.id), 64'(gid));
      end
      rsp_if.ready = 1'b1;
      @(posedge clk);
      @(negedge clk); rsp_if.ready = 1'b0;
      chk("rsp_done", 64'(rsp_if.valid), 64'd0);
      model_serve(gid);
      @(posedge clk);
      @(negedge clk);
      chk("idle_quiet", 64'(rsp_if.valid), 64'd0);
   endtask

   task automatic pulse_reset();
      drop_valids();
      rsp_if.ready = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit          g;
      logic [31:0] d;
      logic        c;
      bit          exp2 [4];
      bit          quiet;
      reset = 1'b1;
      req0_if.valid = 1'b1; req0_if.fun = 4'h0; req0_if.a = 16'h1234; req0_if.b = 16'h0001;
      req1_if.valid = 1'b1; req1_if.fun = 4'h0; req1_if.a = 16'h0; req1_if.b = 16'h0;
      rsp_if.ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'({req1_if.ready, req0_if.ready}), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_if.valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_if.data), 64'd0);
      chk("rst_rsp_misc", 64'({rsp_if.id, rsp_if.flag, rsp_if.carry}), 64'd0);
      chk("rst_alu", 64'({alu_if.a, alu_if.b, alu_if.fun}), 64'd0);
      drop_valids();
      reset = 1'b0;

      // Plain ADD from req0.
      do_op(1, 0, 4'b0000, 16'd5, 16'd3, 4'h0, 16'd0, 16'd0, 0, 0, g, d, c);
      chk("t1_id", 64'(g), 64'd0);
      chk("t1_data", 64'(d), 64'd8);
      chk("t1_carry", 64'(c), 64'd0);

      // Contention from reset: round-robin alternates, fixed priority stays on req0.
      pulse_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp2 = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp2 = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      for (int i = 0; i < 4; i++) begin
         do_op(1, 1, 4'(i), 16'($urandom), 16'($urandom), 4'(4 + i), 16'($urandom), 16'($urandom),
               0, 0, g, d, c);
         chk("t2_grant", 64'(g), 64'(exp2[i]));
      end

      // Stalled logic AND.
      do_op(1, 0, 4'b0100, 16'h00F0, 16'h0FF0, 4'h0, 16'd0, 16'd0, 5, 0, g, d, c);
      chk("t3_data", 64'(d), 64'h00F0);

      // Carry out of ADD, then a compare clears carry and upper bits.
      do_op(1, 0, 4'b0000, 16'hFFFF, 16'h0001, 4'h0, 16'd0, 16'd0, 1, 0, g, d, c);
      chk("t4_carry", 64'(c), 64'd1);
      chk("t4_lo", 64'(d[15:0]), 64'd0);
      do_op(0, 1, 4'h0, 16'd0, 16'd0, 4'b1010, 16'd9, 16'd4, 0, 0, g, d, c);
      chk("t4_cmp_carry", 64'(c), 64'd0);
      chk("t4_cmp_hi", 64'(d[31:2]), 64'd0);

      // Reset while executing discards the operation.
      req0_if.valid = 1'b1; req0_if.fun = 4'b0000; req0_if.a = 16'd7; req0_if.b = 16'd9;
      #1;
      @(posedge clk);
      @(negedge clk); drop_valids();
      reset = 1'b1;
      #1;
      chk("t5_rsp_valid", 64'(rsp_if.valid), 64'd0);
      chk("t5_alu", 64'({alu_if.a, alu_if.b, alu_if.fun}), 64'd0);
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      model_reset();
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (rsp_if.valid) quiet = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      chk("t5_no_rsp", 64'(quiet), 64'd1);
      do_op(0, 1, 4'h0, 16'd0, 16'd0, 4'b0001, 16'd20, 16'd6, 0, 0, g, d, c);
      chk("t5_id", 64'(g), 64'd1);
      chk("t5_data", 64'(d), 64'd14);

      // req1 pokes valid during RESP then drops it.
      do_op(1, 0, 4'b1101, 16'h8001, 16'h0003, 4'h0, 16'd0, 16'd0, 2, 1, g, d, c);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         int v;
         v = $urandom_range(1, 3);
         do_op(v[0], v[1],
               4'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom), 16'($urandom),
               4'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
               $urandom_range(0, 3), 1'($urandom), g, d, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
